alu_arbiter: RTL

Sequencer that shares the single combinational 64-bit Y86 ALU (add/sub/and/xor, 2-bit function code, overflow flag) between two requesters: port 0 for execute-stage OPq and port 1 for address/stack-pointer arithmetic. It arbitrates round-robin, registers operands, drives the ALU, captures the result, and returns it through a valid/ready response. For requests flagged setcc, it updates the condition-code register (ZF, SF, OF).

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one external Y86 ALU between two requesters,
// returning registered results over valid/ready and maintaining ZF/SF/OF.
module alu_arbiter #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_fun0,
  input  logic [1:0]        req_fun1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [1:0]        req_setcc,
  output logic [1:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovf,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  typedef struct packed {
    logic [1:0]        fun;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              setcc;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic              gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt_vld;
  logic              gnt_idx;

  // Single requester wins outright; contention resolved by the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    case (req_valid)
      2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;  end
      2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;  end
      2'b11:   begin gnt_vld = 1'b1; gnt_idx = ptr_q; end
      default: begin gnt_vld = 1'b0; gnt_idx = 1'b0;  end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    rsp_data_d  = rsp_data_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
    cnt_d       = cnt_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    alu_control = 2'b00;
    alu_a       = '0;
    alu_b       = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          gnt_d    = gnt_idx;
          op_d.fun   = gnt_idx ? req_fun1 : req_fun0;
          op_d.a     = gnt_idx ? req_a1   : req_a0;
          op_d.b     = gnt_idx ? req_b1   : req_b0;
          op_d.setcc = req_setcc[gnt_idx];
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_control = op_q.fun;
        alu_a       = op_q.a;
        alu_b       = op_q.b;
        rsp_data_d  = alu_out;
        if (op_q.setcc) begin
          zf_d = (alu_out == '0);
          sf_d = alu_out[DATA_W-1];
          of_d = alu_ovf;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          ptr_d   = ~gnt_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      gnt_q      <= 1'b0;
      ptr_q      <= 1'(PRIO_INIT);
      rsp_data_q <= '0;
      zf_q       <= 1'b1;
      sf_q       <= 1'b0;
      of_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      zf_q       <= zf_d;
      sf_q       <= sf_d;
      of_q       <= of_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign cc_zf    = zf_q;
  assign cc_sf    = sf_q;
  assign cc_of    = of_q;
  assign busy     = (state_q != S_IDLE);
  assign op_count = cnt_q;

endmodule
